data_mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port `data_mem` (8 KiB, 32-bit, byte-enable writes, combinational read) between the core load/store unit (port C) and the boot/DMA copy engine (port D).
- Sits between both masters and `data_mem`, multiplexing one access per cycle onto the memory pins.
- Returns a registered read-data response one cycle after grant.
- Supports bounded DMA burst locking so flash-to-RAM copies are efficient without starving the core.

---
 rtl/data_mem_pkg.sv | 31 +++
 rtl/data_mem_arb_resp.sv | 36 +++
 rtl/data_mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem arbiter slice: port indices,
// arbiter FSM states, memory geometry and the byte-enable qualification helper.
package data_mem_pkg;

  localparam int DMEM_AW  = 13;
  localparam int DMEM_DW  = 32;
  localparam int DMEM_BEW = 4;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_e;

  // Byte enables only reach the memory for writes; reads present an empty mask.
  function automatic logic [DMEM_BEW-1:0] qual_be(input logic we,
                                                 input logic [DMEM_BEW-1:0] be);
    logic [DMEM_BEW-1:0] res;
    if (we) begin
      res = be;
    end else begin
      res = {DMEM_BEW{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_arb_resp.sv
// Per-port response register pair: rvalid follows a grant by one cycle and
// rdata captures the read word (or zero for a write), holding until the next response.
module data_mem_arb_resp
  import data_mem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               gnt_i,
  input  logic               we_i,
  input  logic [DMEM_DW-1:0] mem_rdata_i,
  output logic               rvalid_o,
  output logic [DMEM_DW-1:0] rdata_o
);

  logic               rvalid_r;
  logic [DMEM_DW-1:0] rdata_r;

  // Capture the response at the grant edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DMEM_DW{1'b0}};
    end else begin
      rvalid_r <= gnt_i;
      if (gnt_i) begin
        rdata_r <= we_i ? {DMEM_DW{1'b0}} : mem_rdata_i;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data_mem between the core LSU (C) and the DMA engine (D)
// with bounded DMA burst locking. Define DATA_MEM_ARB_RR_EN for round-robin contests.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                c_req_i,
  input  logic                c_we_i,
  input  logic [DMEM_BEW-1:0] c_be_i,
  input  logic [DMEM_AW-1:0]  c_addr_i,
  input  logic [DMEM_DW-1:0]  c_wdata_i,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DMEM_BEW-1:0] d_be_i,
  input  logic [DMEM_AW-1:0]  d_addr_i,
  input  logic [DMEM_DW-1:0]  d_wdata_i,
  input  logic                d_lock_i,
  output logic                c_gnt_o,
  output logic                d_gnt_o,
  output logic                c_rvalid_o,
  output logic                d_rvalid_o,
  output logic [DMEM_DW-1:0]  c_rdata_o,
  output logic [DMEM_DW-1:0]  d_rdata_o,
  output logic                mem_write_o,
  output logic [DMEM_BEW-1:0] mem_be_sel_o,
  output logic [DMEM_AW-1:0]  mem_addr_o,
  output logic [DMEM_DW-1:0]  mem_data_o,
  input  logic [DMEM_DW-1:0]  mem_data_i
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_e             state_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [CNT_W-1:0]   beat_inc_s;
  logic               yield_r;
  logic               contest_s;
  logic               c_gnt_s;
  logic               d_gnt_s;
  logic               mem_write_s;
  logic [DMEM_BEW-1:0] mem_be_s;
  logic [DMEM_AW-1:0] mem_addr_s;
  logic [DMEM_DW-1:0] mem_data_s;

`ifdef DATA_MEM_ARB_RR_EN
  port_e              rr_ptr_r;  // port that wins the next contested ARB cycle
`endif

  // Grant decision: yield override, base policy in ARB, D priority in BURST.
  always_comb begin
    c_gnt_s   = 1'b0;
    d_gnt_s   = 1'b0;
    contest_s = c_req_i & d_req_i;
    if (rst_i) begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          if (contest_s) begin
            if (yield_r) begin
              c_gnt_s = 1'b1;
            end else begin
`ifdef DATA_MEM_ARB_RR_EN
              if (rr_ptr_r == PORT_C) begin
                c_gnt_s = 1'b1;
              end else begin
                d_gnt_s = 1'b1;
              end
`else
              c_gnt_s = 1'b1;
`endif
            end
          end else begin
            c_gnt_s = c_req_i;
            d_gnt_s = d_req_i;
          end
        end
        BURST: begin
          d_gnt_s = d_req_i;
          c_gnt_s = c_req_i & ~d_req_i;
        end
        default: begin
          c_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Memory pin mux; idle pins are driven to zero.
  always_comb begin
    mem_write_s = 1'b0;
    mem_be_s    = {DMEM_BEW{1'b0}};
    mem_addr_s  = {DMEM_AW{1'b0}};
    mem_data_s  = {DMEM_DW{1'b0}};
    if (c_gnt_s) begin
      mem_write_s = c_we_i;
      mem_be_s    = qual_be(c_we_i, c_be_i);
      mem_addr_s  = c_addr_i;
      mem_data_s  = c_wdata_i;
    end else if (d_gnt_s) begin
      mem_write_s = d_we_i;
      mem_be_s    = qual_be(d_we_i, d_be_i);
      mem_addr_s  = d_addr_i;
      mem_data_s  = d_wdata_i;
    end else begin
      mem_write_s = 1'b0;
      mem_be_s    = {DMEM_BEW{1'b0}};
      mem_addr_s  = {DMEM_AW{1'b0}};
      mem_data_s  = {DMEM_DW{1'b0}};
    end
  end

  // Saturating beat increment so the counter can never wrap.
  always_comb begin
    beat_inc_s = beat_cnt_r;
    if (beat_cnt_r != MAX_CNT) begin
      beat_inc_s = beat_cnt_r + ONE_CNT;
    end else begin
      beat_inc_s = beat_cnt_r;
    end
  end

  // Burst FSM with beat counting and one-cycle yield after a capped burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ARB;
      beat_cnt_r <= {CNT_W{1'b0}};
      yield_r    <= 1'b0;
    end else begin
      yield_r <= 1'b0;
      case (state_r)
        ARB: begin
          if (d_gnt_s && d_lock_i && (MAX_BURST > 1)) begin
            state_r    <= BURST;
            beat_cnt_r <= ONE_CNT;
          end else begin
            state_r    <= ARB;
            beat_cnt_r <= {CNT_W{1'b0}};
          end
        end
        BURST: begin
          if (d_gnt_s && (beat_inc_s == MAX_CNT)) begin
            state_r    <= ARB;
            beat_cnt_r <= {CNT_W{1'b0}};
            yield_r    <= 1'b1;
          end else if (!d_gnt_s || !d_lock_i) begin
            state_r    <= ARB;
            beat_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r    <= BURST;
            beat_cnt_r <= beat_inc_s;
          end
        end
        default: begin
          state_r    <= ARB;
          beat_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef DATA_MEM_ARB_RR_EN
  // Only contested ARB cycles move the round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r <= PORT_C;
    end else if ((state_r == ARB) && contest_s) begin
      rr_ptr_r <= c_gnt_s ? PORT_D : PORT_C;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  data_mem_arb_resp u_resp_c (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gnt_i       (c_gnt_s),
    .we_i        (c_we_i),
    .mem_rdata_i (mem_data_i),
    .rvalid_o    (c_rvalid_o),
    .rdata_o     (c_rdata_o)
  );

  data_mem_arb_resp u_resp_d (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gnt_i       (d_gnt_s),
    .we_i        (d_we_i),
    .mem_rdata_i (mem_data_i),
    .rvalid_o    (d_rvalid_o),
    .rdata_o     (d_rdata_o)
  );

  assign c_gnt_o      = c_gnt_s;
  assign d_gnt_o      = d_gnt_s;
  assign mem_write_o  = mem_write_s;
  assign mem_be_sel_o = mem_be_s;
  assign mem_addr_o   = mem_addr_s;
  assign mem_data_o   = mem_data_s;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench for data_mem_arbiter (MAX_BURST=4) with a behavioural data_mem.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        c_req_i, c_we_i, d_req_i, d_we_i, d_lock_i;
  logic [3:0]  c_be_i, d_be_i;
  logic [12:0] c_addr_i, d_addr_i;
  logic [31:0] c_wdata_i, d_wdata_i;
  logic        c_gnt_o, d_gnt_o, c_rvalid_o, d_rvalid_o;
  logic [31:0] c_rdata_o, d_rdata_o;
  logic        mem_write_o;
  logic [3:0]  mem_be_sel_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_data_o, mem_data_i;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t c_q[$];
  exp_t d_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rr;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_be_i(c_be_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_lock_i(d_lock_i),
    .c_gnt_o(c_gnt_o), .d_gnt_o(d_gnt_o),
    .c_rvalid_o(c_rvalid_o), .d_rvalid_o(d_rvalid_o),
    .c_rdata_o(c_rdata_o), .d_rdata_o(d_rdata_o),
    .mem_write_o(mem_write_o), .mem_be_sel_o(mem_be_sel_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  // Behavioural data_mem: combinational read, byte-enable write, preload while in reset.
  assign mem_data_i = mem[mem_addr_o[12:2]];
  always @(posedge clk) begin
    if (rst_i) begin
      mem[16] <= 32'hDEADBEEF;
      mem[64] <= 32'h11223344;
    end else if (mem_write_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_sel_o[b]) mem[mem_addr_o[12:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are already set at a negedge; check grants/pins, queue expected responses.
  task automatic step(input string tag, input logic eg_c, input logic eg_d,
                      input logic [31:0] er_c, input logic [31:0] er_d);
    logic [49:0] emem;
    exp_t e;
    #1;
    check({tag, "_cgnt"}, {63'd0, c_gnt_o}, {63'd0, eg_c});
    check({tag, "_dgnt"}, {63'd0, d_gnt_o}, {63'd0, eg_d});
    if (eg_c)      emem = {c_we_i, (c_we_i ? c_be_i : 4'b0000), c_addr_i, c_wdata_i};
    else if (eg_d) emem = {d_we_i, (d_we_i ? d_be_i : 4'b0000), d_addr_i, d_wdata_i};
    else           emem = 50'd0;
    check({tag, "_mem"}, {14'd0, mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o}, {14'd0, emem});
    if (eg_c) begin e.cyc = cyc + 1; e.data = er_c; c_q.push_back(e); end
    if (eg_d) begin e.cyc = cyc + 1; e.data = er_d; d_q.push_back(e); end
    @(negedge clk);
  endtask

  // Monitor: cycle counter plus response scoreboard, sampled just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      if (c_rvalid_o) begin
        if (c_q.size() == 0) begin
          check("c_resp_unexpected", {63'd0, c_rvalid_o}, 64'd0);
        end else begin
          e = c_q.pop_front();
          check("c_resp_cycle", 64'(cyc), 64'(e.cyc));
          check("c_rdata", {32'd0, c_rdata_o}, {32'd0, e.data});
        end
      end
      if (d_rvalid_o) begin
        if (d_q.size() == 0) begin
          check("d_resp_unexpected", {63'd0, d_rvalid_o}, 64'd0);
        end else begin
          e = d_q.pop_front();
          check("d_resp_cycle", 64'(cyc), 64'(e.cyc));
          check("d_rdata", {32'd0, d_rdata_o}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef DATA_MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_i = 1'b1;
    c_req_i = 1'b1; c_we_i = 1'b0; c_be_i = 4'hF; c_addr_i = 13'h040; c_wdata_i = 32'h0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 13'h000; d_wdata_i = 32'h0;
    d_lock_i = 1'b0;
    @(negedge clk);
    step("rst0", 1'b0, 1'b0, 32'h0, 32'h0);
    step("rst1", 1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b0; c_req_i = 1'b0; d_req_i = 1'b0;
    check("rst_c_rvalid", {63'd0, c_rvalid_o}, 64'd0);
    check("rst_d_rvalid", {63'd0, d_rvalid_o}, 64'd0);
    check("rst_rdata", {c_rdata_o, d_rdata_o}, 64'd0);
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0);

    // Uncontested read, byte write, read-after-write from the other port
    c_req_i = 1'b1; c_addr_i = 13'h040;
    step("rd", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    c_req_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0001;
    d_addr_i = 13'h100; d_wdata_i = 32'h000000AA;
    step("bw", 1'b0, 1'b1, 32'h0, 32'h0);
    d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = 32'h0; c_req_i = 1'b1; c_addr_i = 13'h100;
    step("rbw", 1'b1, 1'b0, 32'h112233AA, 32'h0);

    // Contention without lock
    c_addr_i = 13'h040; d_req_i = 1'b1; d_addr_i = 13'h100;
    for (int i = 0; i < 4; i++) begin
      step("ct", rr ? (i % 2 == 0) : 1'b1, rr ? (i % 2 == 1) : 1'b0, 32'hDEADBEEF, 32'h112233AA);
    end

    // Burst cap: four locked D beats, yield to C, then base policy
    c_req_i = 1'b0; d_lock_i = 1'b1; d_addr_i = 13'h040;
    step("b1", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    c_req_i = 1'b1; c_addr_i = 13'h100;
    step("b2", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    step("b3", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    step("b4", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    check("cap_yield", {63'd0, dut.yield_r}, 64'd1);
    check("cap_state", 64'(dut.state_r), 64'(ARB));
    check("cap_cnt", 64'(dut.beat_cnt_r), 64'd0);
    step("b5", 1'b1, 1'b0, 32'h112233AA, 32'h0);
    check("yield_clr", {63'd0, dut.yield_r}, 64'd0);
    step("b6", ~rr, rr, 32'h112233AA, 32'hDEADBEEF);
    c_req_i = 1'b0; d_req_i = 1'b0; d_lock_i = 1'b0;
    step("bi", 1'b0, 1'b0, 32'h0, 32'h0);
    check("bi_state", 64'(dut.state_r), 64'(ARB));

    // Early exit when lock drops after beat 2
    d_req_i = 1'b1; d_lock_i = 1'b1;
    step("e1", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    step("e2", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    d_lock_i = 1'b0;
    step("e3", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    check("ee_state", 64'(dut.state_r), 64'(ARB));
    check("ee_yield", {63'd0, dut.yield_r}, 64'd0);
    check("ee_cnt", 64'(dut.beat_cnt_r), 64'd0);
    c_req_i = 1'b1; c_addr_i = 13'h040;
    step("e4", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);

    // Reset asserted during beat 3
    c_req_i = 1'b0; d_lock_i = 1'b1;
    step("r1", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    step("r2", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    rst_i = 1'b1;
    step("r3", 1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b0; d_req_i = 1'b0; d_lock_i = 1'b0;
    check("mr_c_rvalid", {63'd0, c_rvalid_o}, 64'd0);
    check("mr_d_rvalid", {63'd0, d_rvalid_o}, 64'd0);
    check("mr_state", 64'(dut.state_r), 64'(ARB));
    step("r4", 1'b0, 1'b0, 32'h0, 32'h0);
    step("r5", 1'b0, 1'b0, 32'h0, 32'h0);

    check("c_queue_empty", 64'(c_q.size()), 64'd0);
    check("d_queue_empty", 64'(d_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
